key_event_fifo: RTL and testbench
=================================

Name: key_event_fifo

Overview:
Downstream consumer of the keypad decoder. It captures each key code the decoder presents with its strobe, and buffers up to DEPTH codes in arrival order. It presents the oldest code to the MCU input-port mux and holds a level interrupt request to the MCU while unread codes remain. The MCU drains the buffer by reading the port, which pops one entry.

Parameters:
DEPTH, 4, number of buffered key codes; power of two, >= 2
DW, 8, key code width
CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridable)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
KEY_DATA  in  DW  key code from keypad decoder; valid while KEY_STROBE high
KEY_STROBE  in  1  keypad decoder interrupt/valid; may stay high for many cycles per key
POP  in  1  one-cycle pulse from MCU port-read decode; consumes head entry
INTR_EN  in  1  interrupt enable (from MCU output-port register)
CLR_OVF  in  1  one-cycle pulse; clears OVF
IO_DATA  out  DW  head entry; NO_KEY when empty
MCU_INTR  out  1  level interrupt request to MCU
COUNT  out  CW  number of stored entries
EMPTY  out  1  COUNT == 0
FULL  out  1  COUNT == DEPTH
OVF  out  1  sticky: a key was dropped because the buffer was full

Behaviour:
- Reset (async, RST=1): read/write pointers = 0, COUNT = 0, strobe history = 0, OVF = 0; hence EMPTY = 1, FULL = 0, IO_DATA = NO_KEY, MCU_INTR = 0. Reset mid-operation discards all entries immediately.
- Edge detect: strobe_q registers KEY_STROBE. push = KEY_STROBE & ~strobe_q, so one push per strobe assertion regardless of how long it is held. KEY_DATA is sampled at that same clock edge.
- Latency: push at edge k makes COUNT, EMPTY and IO_DATA (if the buffer was empty) reflect the new code after edge k, i.e. 1 cycle. POP at edge k advances the head after edge k.
- IO_DATA is combinational from storage at the read pointer. It equals NO_KEY when EMPTY.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. FULL/EMPTY derive from COUNT, not from pointer comparison.
- push & ~FULL: write at wr_ptr, wr_ptr+1, COUNT+1.
- push & FULL & ~POP: code dropped, storage unchanged, OVF <= 1.
- push & FULL & POP: pop and push both happen, COUNT unchanged, no overflow.
- POP & ~EMPTY: rd_ptr+1, COUNT-1.
- POP & EMPTY: ignored, no state change. This holds even with a simultaneous push; the new code is stored and the pop is not applied to it.
- CLR_OVF & set-condition in the same cycle: set wins, so OVF stays 1.
- MCU_INTR = INTR_EN & ~EMPTY, registered: it updates at the clock edge following the condition change. Deasserting INTR_EN masks the request without losing entries.
- No arithmetic overflow: COUNT never exceeds DEPTH or goes below 0.

Decomposition:
- Package keypad_pkg: KEY_DW = 8, NO_KEY = 8'hFF, and the key-code constants shared with the keypad decoder.
- One sub-module, key_fifo_mem: DEPTH x DW register array with write port (we, waddr, wdata) and async read port (raddr → rdata). It has no reset on storage.
- Top level holds edge detect, pointers, COUNT, OVF and the interrupt register.

Test Plan:
- Reset: assert RST mid-cycle with 2 entries stored → immediately COUNT=0, EMPTY=1, IO_DATA=8'hFF, MCU_INTR=0, OVF=0.
- Single key: KEY_DATA=8'h05 with KEY_STROBE held 10 cycles, INTR_EN=1 → exactly one push. After 1 edge, COUNT=1 and IO_DATA=8'h05; MCU_INTR=1 one edge later. POP → COUNT=0; MCU_INTR=0 one edge later.
- Ordering/wrap: push 8'h01..8'h04, pop 2, push 8'h05, 8'h06 → pops yield 03, 04, 05, 06; pointers wrap past DEPTH-1.
- Overflow: fill with 8'h01..8'h04, push 8'h09 → FULL=1, OVF=1, contents unchanged. Push with simultaneous POP when full → 01 removed, 8'h0A stored, COUNT=4, OVF unchanged. CLR_OVF → OVF=0.
- Empty corner: POP on empty → no change. POP with push of 8'h07 on empty → COUNT=1, IO_DATA=8'h07.
- Masking: 2 entries, INTR_EN=0 → MCU_INTR=0, COUNT=2. INTR_EN=1 → MCU_INTR=1 next edge.

Source files
------------

// File: rtl/keypad_pkg.sv
// Constants shared between the keypad decoder and its consumers.
// Key codes are 8 bits; the all-ones code doubles as "no key pending".
package keypad_pkg;

    localparam int KEY_DW = 8;

    localparam logic [KEY_DW-1:0] NO_KEY   = 8'hFF;

    localparam logic [KEY_DW-1:0] KEY_0    = 8'h00;
    localparam logic [KEY_DW-1:0] KEY_1    = 8'h01;
    localparam logic [KEY_DW-1:0] KEY_2    = 8'h02;
    localparam logic [KEY_DW-1:0] KEY_3    = 8'h03;
    localparam logic [KEY_DW-1:0] KEY_4    = 8'h04;
    localparam logic [KEY_DW-1:0] KEY_5    = 8'h05;
    localparam logic [KEY_DW-1:0] KEY_6    = 8'h06;
    localparam logic [KEY_DW-1:0] KEY_7    = 8'h07;
    localparam logic [KEY_DW-1:0] KEY_8    = 8'h08;
    localparam logic [KEY_DW-1:0] KEY_9    = 8'h09;
    localparam logic [KEY_DW-1:0] KEY_STAR = 8'h0A;
    localparam logic [KEY_DW-1:0] KEY_HASH = 8'h0B;
    localparam logic [KEY_DW-1:0] KEY_A    = 8'h0C;
    localparam logic [KEY_DW-1:0] KEY_B    = 8'h0D;
    localparam logic [KEY_DW-1:0] KEY_C    = 8'h0E;
    localparam logic [KEY_DW-1:0] KEY_D    = 8'h0F;

    function automatic logic is_digit(input logic [KEY_DW-1:0] code);
        return code <= KEY_9;
    endfunction

endpackage

// File: rtl/key_fifo_mem.sv
// DEPTH x DW storage for the key event buffer: synchronous write, asynchronous read.
// Storage is deliberately unreset; validity is tracked by the occupancy count above it.
module key_fifo_mem #(
    parameter  int DEPTH = 4,
    parameter  int DW    = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/key_event_fifo.sv
// Buffers key codes from the keypad decoder for the MCU: one entry per strobe rising edge,
// oldest code on IO_DATA, level interrupt while entries remain, sticky overflow flag.
module key_event_fifo
    import keypad_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int DW    = KEY_DW,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] KEY_DATA,
    input  logic          KEY_STROBE,
    input  logic          POP,
    input  logic          INTR_EN,
    input  logic          CLR_OVF,
    output logic [DW-1:0] IO_DATA,
    output logic          MCU_INTR,
    output logic [CW-1:0] COUNT,
    output logic          EMPTY,
    output logic          FULL,
    output logic          OVF
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] NO_CODE = DW'(NO_KEY);

    logic          strobe_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf_q;
    logic          intr_q;
    logic [DW-1:0] head_data;

    logic push;
    logic do_push;
    logic do_pop;
    logic ovf_set;
    logic empty;
    logic full;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop on an empty buffer is dropped even if a key arrives in the same cycle,
    // and a push into a full buffer is only accepted when a real pop frees a slot.
    assign push    = KEY_STROBE & ~strobe_q;
    assign do_pop  = POP & ~empty;
    assign do_push = push & (~full | do_pop);
    assign ovf_set = push & full & ~POP;

    key_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clk   (CLK),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (KEY_DATA),
        .raddr (rd_ptr),
        .rdata (head_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            strobe_q <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_q    <= 1'b0;
            intr_q   <= 1'b0;
        end else begin
            strobe_q <= KEY_STROBE;
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
            // Setting wins over clearing so a drop in the clear cycle is never lost.
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (CLR_OVF) begin
                ovf_q <= 1'b0;
            end
            intr_q <= INTR_EN & ~empty;
        end
    end

    assign IO_DATA  = empty ? NO_CODE : head_data;
    assign MCU_INTR = intr_q;
    assign COUNT    = count;
    assign EMPTY    = empty;
    assign FULL     = full;
    assign OVF      = ovf_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Bench for key_event_fifo: directed scenarios plus random traffic, all checked against
// a queue-based model of the key buffer that is stepped once per clock edge.
module tb_key_event_fifo;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic [DW-1:0] key_data;
    logic          key_strobe;
    logic          pop;
    logic          intr_en;
    logic          clr_ovf;
    logic [DW-1:0] io_data;
    logic          mcu_intr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          ovf;

    int n_checks;
    int n_errors;

    logic [DW-1:0] model_q[$];
    logic          model_prev_strobe;
    logic          model_ovf;
    logic          model_intr;

    key_event_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .KEY_DATA   (key_data),
        .KEY_STROBE (key_strobe),
        .POP        (pop),
        .INTR_EN    (intr_en),
        .CLR_OVF    (clr_ovf),
        .IO_DATA    (io_data),
        .MCU_INTR   (mcu_intr),
        .COUNT      (count),
        .EMPTY      (empty),
        .FULL       (full),
        .OVF        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_prev_strobe = 1'b0;
        model_ovf         = 1'b0;
        model_intr        = 1'b0;
    endtask

    // One clock edge of the buffer, phrased as queue operations.
    task automatic modelStep(input logic strobe, input logic [DW-1:0] data, input logic p,
                             input logic clr, input logic ien);
        logic new_key;
        logic pop_ok;
        logic drop;
        new_key           = strobe && !model_prev_strobe;
        model_prev_strobe = strobe;
        model_intr        = ien && (model_q.size() != 0);
        pop_ok            = p && (model_q.size() != 0);
        drop              = new_key && (model_q.size() == DEPTH) && !pop_ok;
        if (pop_ok) void'(model_q.pop_front());
        if (new_key && !drop) model_q.push_back(data);
        if (drop) model_ovf = 1'b1;
        else if (clr) model_ovf = 1'b0;
    endtask

    task automatic checkAll(input string tag);
        int n;
        n = model_q.size();
        checkOutput({tag, ".count"}, 32'(count), 32'(n));
        checkOutput({tag, ".empty"}, 32'(empty), 32'(n == 0));
        checkOutput({tag, ".full"},  32'(full),  32'(n == DEPTH));
        checkOutput({tag, ".io_data"}, 32'(io_data), (n == 0) ? 32'hFF : 32'(model_q[0]));
        checkOutput({tag, ".ovf"},  32'(ovf),      32'(model_ovf));
        checkOutput({tag, ".intr"}, 32'(mcu_intr), 32'(model_intr));
    endtask

    task automatic applyStimulus(input logic strobe, input logic [DW-1:0] data, input logic p,
                                 input logic clr, input logic ien, input string tag);
        key_strobe = strobe;
        key_data   = data;
        pop        = p;
        clr_ovf    = clr;
        intr_en    = ien;
        @(posedge clk);
        modelStep(strobe, data, p, clr, ien);
        #1;
        checkAll(tag);
    endtask

    task automatic pushKey(input logic [DW-1:0] code, input string tag);
        applyStimulus(1'b1, code, 1'b0, 1'b0, 1'b1, tag);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, tag);
    endtask

    task automatic popKey(input string tag);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, tag);
    endtask

    task automatic asyncReset(input string tag);
        key_strobe = 1'b0;
        pop        = 1'b0;
        clr_ovf    = 1'b0;
        #2 rst = 1'b1;
        modelReset();
        #1;
        checkAll(tag);
        #3 rst = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        key_data   = 8'h00;
        key_strobe = 1'b0;
        pop        = 1'b0;
        intr_en    = 1'b0;
        clr_ovf    = 1'b0;
        modelReset();
        #12;
        checkAll("reset");
        #4 rst = 1'b0;

        // Held strobe yields a single entry; interrupt follows one edge later.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, 1'b1, "hold");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "hold_end");
        popKey("single_pop");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "single_idle");

        // Ordering with pointer wrap.
        for (int i = 1; i <= 4; i++) pushKey(8'(i), "order_fill");
        popKey("order_pop");
        popKey("order_pop");
        pushKey(8'h05, "wrap_push");
        pushKey(8'h06, "wrap_push");
        for (int i = 0; i < 4; i++) popKey("wrap_drain");

        // Overflow, push-with-pop when full, clear, and set-beats-clear.
        for (int i = 1; i <= 4; i++) pushKey(8'(i), "ovf_fill");
        pushKey(8'h09, "ovf_drop");
        applyStimulus(1'b1, 8'h0A, 1'b1, 1'b0, 1'b1, "full_push_pop");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, "ovf_clear");
        applyStimulus(1'b1, 8'h0B, 1'b0, 1'b1, 1'b1, "ovf_set_wins");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, "ovf_clear2");
        for (int i = 0; i < 4; i++) popKey("ovf_drain");

        // Empty corner cases.
        popKey("empty_pop");
        applyStimulus(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, "empty_pop_push");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "empty_pop_push_idle");

        // Masking the interrupt keeps entries.
        pushKey(8'h0C, "mask_fill");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "mask_off");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "mask_off");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "mask_on");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "mask_on");

        // Reset between edges discards stored entries at once.
        asyncReset("mid_reset");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "post_reset");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic          s;
            logic          p;
            logic          c;
            logic          e;
            logic [DW-1:0] d;
            s = ($urandom_range(0, 99) < 50);
            p = ($urandom_range(0, 99) < 30);
            c = ($urandom_range(0, 99) < 6);
            e = ($urandom_range(0, 99) < 85);
            d = 8'($urandom);
            applyStimulus(s, d, p, c, e, "random");
            if (i == 200) asyncReset("random_reset");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
